// File: rtl/key_dispatcher_pkg.sv
// rtl/key_dispatcher_pkg.sv - shared types and defaults for the RC4 key dispatcher
// Purpose: dispatcher FSM state encoding and default key-space constants.
// Ports: none (package).
package key_dispatcher_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      HALTED    = 2'd2,
      EXHAUSTED = 2'd3
   } disp_state_t;

   localparam int          KEY_WIDTH_DEFAULT = 24;
   localparam logic [23:0] KEY_LIMIT_DEFAULT = 24'h3FFFFF;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with masking and a registered pointer
// Purpose: pick the first unmasked requester at or after the pointer, cyclically.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   clr         : force the pointer back to 0
//   req         : per-requester request
//   mask        : requesters excluded from this cycle's arbitration
//   advance     : winner is taken this cycle; move pointer past it
//   winner      : one-hot combinational winner (all zero when nobody eligible)
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic         advance,
   output logic [N-1:0] winner
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [N-1:0]     req_m;
   logic [PTR_W-1:0] win_idx;
   logic             hit;
   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;

   assign req_m = req & ~mask;

   // Scan N positions starting at the pointer; the first eligible one wins.
   always_comb begin
      winner  = '0;
      win_idx = '0;
      hit     = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(N)) begin
            sum = sum - (PTR_W+1)'(N);
         end
         idx = sum[PTR_W-1:0];
         if (!hit && req_m[idx]) begin
            hit         = 1'b1;
            winner[idx] = 1'b1;
            win_idx     = idx;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (advance && hit) begin
         if (win_idx == PTR_W'(N - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win_idx + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/key_dispatcher.sv
// rtl/key_dispatcher.sv - shared-counter key dispatcher for the multi-core RC4 search
// Purpose: hand out keys 0..KEY_LIMIT to requesting cores, one grant per cycle,
//          round-robin; stop on found or when the key space is used up.
// Ports:
//   inclk, reset_n : clock, synchronous active-low reset
//   start          : pulse; (re)starts dispatch from key 0 (ignored while running)
//   found          : a core has matched; halts dispatch
//   req            : per-core key request (level)
//   grant          : one-hot, one-cycle pulse to the core receiving key_out
//   key_out        : key issued with grant; holds between grants
//   busy           : dispatch running
//   exhausted      : last key was issued without a match (sticky)
//   halted         : dispatch stopped by found (sticky)
module key_dispatcher
   import key_dispatcher_pkg::*;
#(
   parameter int                   N_CORES   = 4,
   parameter int                   KEY_WIDTH = KEY_WIDTH_DEFAULT,
   parameter logic [KEY_WIDTH-1:0] KEY_LIMIT = KEY_LIMIT_DEFAULT
) (
   input  logic                 inclk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 found,
   input  logic [N_CORES-1:0]   req,
   output logic [N_CORES-1:0]   grant,
   output logic [KEY_WIDTH-1:0] key_out,
   output logic                 busy,
   output logic                 exhausted,
   output logic                 halted
);

   disp_state_t          state_q, state_d;
   logic [KEY_WIDTH-1:0] next_key_q, next_key_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [N_CORES-1:0]   grant_q, grant_d;

   logic [N_CORES-1:0]   winner;
   logic                 arb_clr;
   logic                 last_issued;
   logic                 take;

   // The final key is on the outputs this cycle; no more grants may follow it.
   assign last_issued = (|grant_q) && (key_q == KEY_LIMIT);

   // found always beats a grant in the same cycle.
   assign take = (state_q == RUN) && !found && !last_issued && (|winner);

   // Cores granted this cycle are masked so a req that is still falling
   // cannot win a second key.
   rr_arbiter #(
      .N (N_CORES)
   ) u_arb (
      .clk     (inclk),
      .resetn  (reset_n),
      .clr     (arb_clr),
      .req     (req),
      .mask    (grant_q),
      .advance (take),
      .winner  (winner)
   );

   always_comb begin
      state_d    = state_q;
      next_key_d = next_key_q;
      key_d      = key_q;
      grant_d    = '0;
      arb_clr    = 1'b0;
      case (state_q)
         IDLE, HALTED, EXHAUSTED: begin
            if (start) begin
               state_d    = RUN;
               next_key_d = '0;
               arb_clr    = 1'b1;
            end
         end
         RUN: begin
            if (found) begin
               state_d = HALTED;
            end else if (last_issued) begin
               state_d = EXHAUSTED;
            end else if (take) begin
               grant_d = winner;
               key_d   = next_key_q;
               // Hold at KEY_LIMIT so the counter never wraps.
               if (next_key_q != KEY_LIMIT) begin
                  next_key_d = next_key_q + KEY_WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge inclk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         next_key_q <= '0;
         key_q      <= '0;
         grant_q    <= '0;
      end else begin
         state_q    <= state_d;
         next_key_q <= next_key_d;
         key_q      <= key_d;
         grant_q    <= grant_d;
      end
   end

   assign grant     = grant_q;
   assign key_out   = key_q;
   assign busy      = (state_q == RUN);
   assign exhausted = (state_q == EXHAUSTED);
   assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_key_dispatcher.sv
// tb/tb_key_dispatcher.sv - directed self-checking bench for key_dispatcher
module tb_key_dispatcher;
   import key_dispatcher_pkg::*;

   logic        inclk;
   logic        reset_n;
   logic        start;
   logic        found;
   logic [3:0]  req;

   logic [3:0]  grant, l_grant;
   logic [23:0] key_out, l_key_out;
   logic        busy, exhausted, halted;
   logic        l_busy, l_exhausted, l_halted;

   int n_tests = 0;
   int n_fail  = 0;

   key_dispatcher u_dut (
      .inclk     (inclk),
      .reset_n   (reset_n),
      .start     (start),
      .found     (found),
      .req       (req),
      .grant     (grant),
      .key_out   (key_out),
      .busy      (busy),
      .exhausted (exhausted),
      .halted    (halted)
   );

   key_dispatcher #(
      .KEY_LIMIT (24'h000005)
   ) u_lim (
      .inclk     (inclk),
      .reset_n   (reset_n),
      .start     (start),
      .found     (found),
      .req       (req),
      .grant     (l_grant),
      .key_out   (l_key_out),
      .busy      (l_busy),
      .exhausted (l_exhausted),
      .halted    (l_halted)
   );

   initial inclk = 1'b0;
   always #5 inclk = ~inclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge inclk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   task automatic do_start(input logic [3:0] r);
      req   = r;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      found   = 1'b0;
      req     = 4'b0000;
      step();
      step();
      reset_n = 1'b1;

      // reset state
      check("rst_grant",     32'(grant), 32'h0);
      check("rst_key",       32'(key_out), 32'h0);
      check("rst_busy",      32'(busy), 32'h0);
      check("rst_exhausted", 32'(exhausted), 32'h0);
      check("rst_halted",    32'(halted), 32'h0);
      check("rst_state",     32'(u_dut.state_q), 32'(IDLE));

      // single requester, drops req after its grant
      do_start(4'b0001);
      check("t1_busy",      32'(busy), 32'h1);
      check("t1_no_grant0", 32'(grant), 32'h0);
      step();
      check("t1_grant", 32'(grant), 32'h1);
      check("t1_key",   32'(key_out), 32'h0);
      req = 4'b0000;
      step();
      check("t1_no_grant1", 32'(grant), 32'h0);
      step();
      check("t1_no_grant2", 32'(grant), 32'h0);
      check("t1_key_hold",  32'(key_out), 32'h0);

      // all cores requesting; u_lim exhausts after key 5
      do_reset();
      do_start(4'b1111);
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("t2_grant_%0d", i), 32'(grant), 32'(4'b0001 << (i % 4)));
         check($sformatf("t2_key_%0d", i),   32'(key_out), 32'(i));
         if (i <= 5) begin
            check($sformatf("lim_grant_%0d", i), 32'(l_grant), 32'(4'b0001 << (i % 4)));
            check($sformatf("lim_key_%0d", i),   32'(l_key_out), 32'(i));
            check($sformatf("lim_exh_%0d", i),   32'(l_exhausted), 32'h0);
         end else begin
            check($sformatf("lim_grant_%0d", i), 32'(l_grant), 32'h0);
            check($sformatf("lim_exh_%0d", i),   32'(l_exhausted), 32'h1);
            check($sformatf("lim_busy_%0d", i),  32'(l_busy), 32'h0);
            check($sformatf("lim_keyhold_%0d", i), 32'(l_key_out), 32'h5);
         end
      end

      // found with grantable requests: no grant, halt, key held, restart at core 0
      req   = 4'b0110;
      found = 1'b1;
      step();
      found = 1'b0;
      check("t4_no_grant", 32'(grant), 32'h0);
      check("t4_halted",   32'(halted), 32'h1);
      check("t4_busy",     32'(busy), 32'h0);
      check("t4_key_hold", 32'(key_out), 32'h9);
      step();
      check("t4_halted_sticky", 32'(halted), 32'h1);
      check("t4_no_grant2",     32'(grant), 32'h0);
      do_start(4'b0110);
      check("t4_busy_restart",  32'(busy), 32'h1);
      check("t4_halted_clear",  32'(halted), 32'h0);
      step();
      check("t4_restart_grant", 32'(grant), 32'b0010);
      check("t4_restart_key",   32'(key_out), 32'h0);

      // found while the final key is on the outputs
      do_reset();
      do_start(4'b1111);
      for (int i = 0; i < 6; i++) begin
         step();
      end
      check("t5_final_key",   32'(l_key_out), 32'h5);
      check("t5_final_grant", 32'(l_grant), 32'b0010);
      found = 1'b1;
      step();
      found = 1'b0;
      check("t5_halted",    32'(l_halted), 32'h1);
      check("t5_exhausted", 32'(l_exhausted), 32'h0);
      check("t5_no_grant",  32'(l_grant), 32'h0);
      step();
      check("t5_halted_sticky", 32'(l_halted), 32'h1);
      check("t5_exh_still0",    32'(l_exhausted), 32'h0);

      // reset mid-RUN after key 0x123
      do_reset();
      do_start(4'b1111);
      for (int i = 0; i <= 'h123; i++) begin
         step();
      end
      check("t6_key_123",   32'(key_out), 32'h123);
      check("t6_grant_123", 32'(grant), 32'b1000);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check("t6_grant",     32'(grant), 32'h0);
      check("t6_key",       32'(key_out), 32'h0);
      check("t6_busy",      32'(busy), 32'h0);
      check("t6_exhausted", 32'(exhausted), 32'h0);
      check("t6_halted",    32'(halted), 32'h0);
      check("t6_state",     32'(u_dut.state_q), 32'(IDLE));
      check("t6_counter",   32'(u_dut.next_key_q), 32'h0);
      do_start(4'b1111);
      step();
      check("t6_first_grant", 32'(grant), 32'b0001);
      check("t6_first_key",   32'(key_out), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
